// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch sequencer. Drives a combinational-read
//               instruction memory with the program counter, registers the
//               returned word for the decoder, and handles start, stall,
//               branch redirect (one-cycle flush) and halt.
//
//               Optional feature macro: FETCH_INSTR_COUNT_EN
//                 defined   -> 16-bit retired-instruction counter on
//                              instr_count
//                 undefined -> instr_count tied to 0, no counter register
//
// Ports       : clk            clock, rising-edge
//               rst_n          asynchronous active-low reset
//               start          pulse: (re)start execution at START_ADDR
//               stall          downstream hold, freezes fetch state
//               halt           halt flag for the presented instruction
//               branch_taken   redirect request for the presented instruction
//               branch_target  redirect address
//               imem_addr      instruction memory address (= pc)
//               imem_rdata     instruction memory data, same cycle as addr
//               instruction    registered instruction to the decoder
//               instr_pc       address the instruction was fetched from
//               instr_valid    instruction / instr_pc are live
//               done           program has halted
//               instr_count    retired-instruction count
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                  PC_WIDTH    = 10,
  parameter int                  INSTR_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0] START_ADDR  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   halt,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  output logic                   done,
  output logic [15:0]            instr_count
);

  localparam logic [PC_WIDTH-1:0] c_pc_one = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instruction;
  logic [PC_WIDTH-1:0]    r_instr_pc;
  logic                   r_instr_valid;
  logic                   r_done;

  // One-hot action strobes for the datapath, decoded from state and inputs.
  logic                   w_load_start;
  logic                   w_take_halt;
  logic                   w_take_branch;
  logic                   w_fetch;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and action decode
  //   Control inputs only act on a live instruction and only when not
  //   stalled; halt has priority over branch so a halting instruction never
  //   redirects. start is ignored while already running.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_load_start  = 1'b0;
    w_take_halt   = 1'b0;
    w_take_branch = 1'b0;
    w_fetch       = 1'b0;

    case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          w_next_state = S_RUN;
          w_load_start = 1'b1;
        end
      end

      S_RUN: begin
        if (!stall) begin
          if (r_instr_valid && halt) begin
            w_next_state = S_HALTED;
            w_take_halt  = 1'b1;
          end else if (r_instr_valid && branch_taken) begin
            w_take_branch = 1'b1;
          end else begin
            w_fetch = 1'b1;
          end
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch datapath
  //   On a branch or halt the presented instruction/instr_pc are left as they
  //   were; only instr_valid drops, which is all the decoder looks at.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= START_ADDR;
      r_instruction <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      if (w_load_start) begin
        // First cycle of a run is a bubble while memory returns START_ADDR.
        r_pc          <= START_ADDR;
        r_instr_valid <= 1'b0;
        r_done        <= 1'b0;
      end else if (w_take_halt) begin
        r_instr_valid <= 1'b0;
        r_done        <= 1'b1;
      end else if (w_take_branch) begin
        // One-cycle flush: target word is fetched this cycle, valid next.
        r_pc          <= branch_target;
        r_instr_valid <= 1'b0;
      end else if (w_fetch) begin
        r_instruction <= imem_rdata;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
        r_pc          <= r_pc + c_pc_one;   // natural wrap at 2^PC_WIDTH
      end
    end
  end

  // --------------------------------------------------------------------------
  // Retired-instruction counter (optional)
  //   Every live, unstalled instruction retires, including branches and the
  //   halting instruction itself.
  // --------------------------------------------------------------------------
`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] r_instr_count;
  logic        w_retire;

  assign w_retire = (r_state == S_RUN) && r_instr_valid && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= 16'd0;
    end else if (w_load_start) begin
      r_instr_count <= 16'd0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = 16'd0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr   = r_pc;
  assign instruction = r_instruction;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Two instances share the
//               control inputs: dut_a at default widths (PC_WIDTH=10) and
//               dut_b with PC_WIDTH=4 for wrap-around. A directed vector
//               table, hand-written wrap/reset sequences and a randomized
//               phase are all checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, halt, branch_taken;
  logic [9:0] branch_target;

  logic [9:0]  a_addr, a_ipc;
  logic [8:0]  a_rdata, a_instr;
  logic        a_valid, a_done;
  logic [15:0] a_cnt;
  logic [3:0]  b_addr, b_ipc, b_tgt;
  logic [8:0]  b_rdata, b_instr;
  logic        b_valid, b_done;
  logic [15:0] b_cnt;

  logic [8:0] mem_a [1024];
  logic [8:0] mem_b [16];

  assign a_rdata = mem_a[a_addr];
  assign b_rdata = mem_b[b_addr];
  assign b_tgt   = branch_target[3:0];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(a_addr), .imem_rdata(a_rdata), .instruction(a_instr),
    .instr_pc(a_ipc), .instr_valid(a_valid), .done(a_done),
    .instr_count(a_cnt)
  );

  fetch_unit #(.PC_WIDTH(4), .INSTR_WIDTH(9), .START_ADDR(4'd0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_target(b_tgt),
    .imem_addr(b_addr), .imem_rdata(b_rdata), .instruction(b_instr),
    .instr_pc(b_ipc), .instr_valid(b_valid), .done(b_done),
    .instr_count(b_cnt)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: "running" and "done" flags plus the visible registers.
  // --------------------------------------------------------------------------
  typedef struct {
    bit running;
    bit done;
    bit valid;
    int pc;
    int ipc;
    int instr;
    int cnt;
  } model_t;

  model_t ma, mb;

  function automatic model_t m_reset();
    model_t s;
    s.running = 0; s.done = 0; s.valid = 0;
    s.pc = 0; s.ipc = 0; s.instr = 0; s.cnt = 0;
    return s;
  endfunction

  function automatic model_t m_step(model_t s, int w, int rdata, bit st,
                                    bit sl, bit hl, bit br, int tgt);
    model_t n = s;
    int span = 1 << w;
    if (st && !s.running) begin
      n.running = 1; n.done = 0; n.valid = 0; n.pc = 0; n.cnt = 0;
    end else if (s.running && !sl) begin
      if (s.valid) n.cnt = (s.cnt + 1) % 65536;
      if (s.valid && hl) begin
        n.running = 0; n.done = 1; n.valid = 0;
      end else if (s.valid && br) begin
        n.pc = tgt % span; n.valid = 0;
      end else begin
        n.instr = rdata; n.ipc = s.pc; n.valid = 1; n.pc = (s.pc + 1) % span;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= m_reset();
      mb <= m_reset();
    end else begin
      ma <= m_step(ma, 10, int'(mem_a[ma.pc]), start, stall, halt,
                   branch_taken, int'(branch_target));
      mb <= m_step(mb, 4, int'(mem_b[mb.pc]), start, stall, halt,
                   branch_taken, int'(branch_target));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.valid", a_valid, ma.valid);
      chk("a.done",  a_done,  ma.done);
      chk("a.addr",  a_addr,  ma.pc);
      chk("a.count", a_cnt,   CNT_EN ? ma.cnt : 0);
      if (ma.valid) begin
        chk("a.instr_pc", a_ipc,   ma.ipc);
        chk("a.instr",    a_instr, ma.instr);
      end
      chk("b.valid", b_valid, mb.valid);
      chk("b.done",  b_done,  mb.done);
      chk("b.addr",  b_addr,  mb.pc);
      chk("b.count", b_cnt,   CNT_EN ? mb.cnt : 0);
      if (mb.valid) begin
        chk("b.instr_pc", b_ipc,   mb.ipc);
        chk("b.instr",    b_instr, mb.instr);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed vector table (expected outputs of dut_a after the edge)
  // --------------------------------------------------------------------------
  typedef struct {
    bit st, sl, hl, br;
    int tgt;
    bit ev;
    int eipc;
    bit ed;
    int ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit st, input bit sl, input bit hl, input bit br,
                     input int tgt, input bit ev, input int eipc,
                     input bit ed, input int ecnt);
    vec_t v;
    v.st = st; v.sl = sl; v.hl = hl; v.br = br; v.tgt = tgt;
    v.ev = ev; v.eipc = eipc; v.ed = ed; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit st, input bit sl, input bit hl, input bit br,
                       input int tgt);
    start = st; stall = sl; halt = hl; branch_taken = br;
    branch_target = tgt[9:0];
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, a_valid, 0);  chk({tag, ".done"}, a_done, 0);
    chk({tag, ".addr"},  a_addr, 0);   chk({tag, ".ipc"},  a_ipc, 0);
    chk({tag, ".instr"}, a_instr, 0);  chk({tag, ".cnt"},  a_cnt, 0);
    chk({tag, ".b_valid"}, b_valid, 0); chk({tag, ".b_addr"}, b_addr, 0);
    chk({tag, ".b_done"},  b_done, 0);  chk({tag, ".b_cnt"},  b_cnt, 0);
  endtask

  initial begin
    vec_t v;
    bit   found;
    logic [9:0] ev_ipc;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) mem_a[i] = 9'(i);
    for (int i = 0; i < 16; i++)   mem_b[i] = 9'(i);

    // Sequence A: start, fetch 0..9 with a 3-cycle stall (plus ignored halt)
    // at instr_pc 7, then halt+branch together at instr_pc 9.
    add(1, 0, 0, 0, 0,     0, 0, 0, 0);
    add(0, 0, 1, 1, 'h40,  1, 0, 0, 0);    // halt/branch with no live instr
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 0, 0, 1, i, 0, i);
    for (int i = 0; i < 3; i++)  add(0, 1, 1, 0, 0, 1, 7, 0, 7);
    add(0, 0, 0, 0, 0,     1, 8, 0, 8);
    add(0, 0, 0, 0, 0,     1, 9, 0, 9);
    add(0, 0, 1, 1, 'h40,  0, 0, 1, 10);
    add(0, 0, 0, 0, 0,     0, 0, 1, 10);   // stays halted
    // Sequence B: restart from HALTED, branch to 0x40 at instr_pc 5.
    add(1, 0, 0, 0, 0,     0, 0, 0, 0);
    for (int i = 0; i <= 5; i++) add(0, 0, 0, 0, 0, 1, i, 0, i);
    add(0, 0, 0, 1, 'h40,  0, 0, 0, 6);    // bubble
    add(0, 0, 0, 1, 'h100, 1, 'h40, 0, 6); // branch during bubble ignored
    add(0, 0, 0, 0, 0,     1, 'h41, 0, 7);
    add(1, 0, 0, 0, 0,     1, 'h42, 0, 8); // start while running ignored
    add(0, 0, 1, 0, 0,     0, 0, 1, 9);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.valid", a_valid, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      drive(v.st, v.sl, v.hl, v.br, v.tgt);
      @(negedge clk);
      chk($sformatf("tbl[%0d].valid", r), a_valid, v.ev);
      chk($sformatf("tbl[%0d].done", r),  a_done,  v.ed);
      chk($sformatf("tbl[%0d].count", r), a_cnt,   CNT_EN ? v.ecnt : 0);
      if (v.ev) begin
        ev_ipc = v.eipc[9:0];
        chk($sformatf("tbl[%0d].instr_pc", r), a_ipc, ev_ipc);
        chk($sformatf("tbl[%0d].instr", r),    a_instr, ev_ipc[8:0]);
      end
    end

    // Wrap: 4-bit PC runs through 15 and continues at 0.
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (b_valid && b_ipc == 4'd15) found = 1'b1;
    end
    chk("wrap.reach15", found, 1);
    @(negedge clk);
    chk("wrap.valid", b_valid, 1);
    chk("wrap.instr_pc", b_ipc, 0);
    chk("wrap.instr", b_instr, 0);

    // Asynchronous reset mid-run, between clock edges.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("postrst.valid", a_valid, 0);
    chk("postrst.addr", a_addr, 0);
    chk("postrst.b_valid", b_valid, 0);

    // Randomized phase against the model.
    for (int i = 0; i < 1024; i++) mem_a[i] = 9'($urandom);
    for (int i = 0; i < 16; i++)   mem_b[i] = 9'($urandom);
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(31) == 0, $urandom_range(3) == 0,
            $urandom_range(15) == 0, $urandom_range(7) == 0,
            int'($urandom_range(1023)));
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
